sram_1rw1r_sync: RTL

Synthesizable, parametrised 1RW+1R synchronous SRAM for the RISC-V SoC's instruction, data and tag stores. It replaces the fixed 20x256 macro model in simulation and FPGA builds, and it is the behavioural golden model for the hard macro.
It runs from one clock and adds several features:
- per-lane write masks;
- read-during-write bypass between ports;
- collision reporting;
- an automatic array-clear sweep after reset.

---
 rtl/sram_pkg.sv | 40 ++++
 rtl/sram_init_seq.sv | 57 +++++
 rtl/sram_1rw1r_sync.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// =============================================================================
// Module   : sram_pkg
// Purpose  : Shared FSM encodings and lane helpers for the 1RW+1R SRAM.
// Revision : 1.0
// =============================================================================
`default_nettype none

package sram_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } init_state_e;

    // Widest word the lane helper supports; callers zero-extend into it.
    localparam int c_MAX_DATA_WIDTH = 256;

    function automatic int lane_width(input int data_width, input int wmask_width);
        return data_width / wmask_width;
    endfunction

    function automatic logic [c_MAX_DATA_WIDTH-1:0] merge_lanes(
        input logic [c_MAX_DATA_WIDTH-1:0] old_word,
        input logic [c_MAX_DATA_WIDTH-1:0] new_word,
        input logic [c_MAX_DATA_WIDTH-1:0] mask,
        input int                          lane_w
    );
        logic [c_MAX_DATA_WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < c_MAX_DATA_WIDTH; i++) begin
            if (mask[i / lane_w]) begin
                result[i] = new_word[i];
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_init_seq.sv
// =============================================================================
// Module   : sram_init_seq
// Purpose  : Post-reset clear sweep: INIT/READY FSM plus sweep address counter.
// Revision : 1.0
// =============================================================================
`default_nettype none

module sram_init_seq
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int RAM_DEPTH     = 256,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy_o,
    output logic                  init_we_o,
    output logic [ADDR_WIDTH-1:0] init_addr_o
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    init_state_e           state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT_ON_RESET ? ST_INIT : ST_READY;
            addr_q  <= '0;
            busy_q  <= INIT_ON_RESET;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (addr_q == c_LAST_ADDR) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                        addr_q  <= '0;
                    end else begin
                        addr_q  <= addr_q + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign init_busy_o = busy_q;
    assign init_we_o   = busy_q;
    assign init_addr_o = addr_q;

endmodule

`default_nettype wire

// File: rtl/sram_1rw1r_sync.sv
// =============================================================================
// Module   : sram_1rw1r_sync
// Purpose  : Parametrised 1RW+1R synchronous SRAM with lane masks, bypass,
//            collision reporting and a post-reset clear sweep.
// Revision : 1.0
// =============================================================================
`default_nettype none

module sram_1rw1r_sync
    import sram_pkg::*;
#(
    parameter int                DATA_WIDTH    = 20,
    parameter int                ADDR_WIDTH    = 8,
    parameter int                RAM_DEPTH     = 1 << ADDR_WIDTH,
    parameter int                WMASK_WIDTH   = 4,
    parameter bit                BYPASS        = 1'b1,
    parameter bit                INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   init_busy,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   dout0_valid,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dout1_valid,
    output logic                   collision
);

    localparam int c_LANE_W = lane_width(DATA_WIDTH, WMASK_WIDTH);

    if ((WMASK_WIDTH < 1) || (DATA_WIDTH < 1) || (DATA_WIDTH > c_MAX_DATA_WIDTH) ||
        ((DATA_WIDTH % WMASK_WIDTH) != 0) || (RAM_DEPTH < 1) ||
        (ADDR_WIDTH < 1) || (ADDR_WIDTH > 31) ||
        (RAM_DEPTH > (1 << ADDR_WIDTH))) begin : g_bad_params
        $fatal(1, "sram_1rw1r_sync: illegal parameter set");
    end

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  w_busy;
    logic                  w_init_we;
    logic [ADDR_WIDTH-1:0] w_init_addr;

    sram_init_seq #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .RAM_DEPTH     (RAM_DEPTH),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_init_seq (
        .clk         (clk),
        .rst         (rst),
        .init_busy_o (w_busy),
        .init_we_o   (w_init_we),
        .init_addr_o (w_init_addr)
    );

    assign init_busy = w_busy;

    logic                  w_addr0_ok;
    logic                  w_addr1_ok;
    logic                  w_wr0;
    logic                  w_rd0;
    logic                  w_rd1;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_old0;
    logic [DATA_WIDTH-1:0] w_old1;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_rd1_data;

    assign w_addr0_ok = 32'(addr0) < 32'(RAM_DEPTH);
    assign w_addr1_ok = 32'(addr1) < 32'(RAM_DEPTH);

    // Out-of-range writes and all-zero masks never touch the array.
    assign w_wr0 = !rst && !w_busy && !csb0 && !web0 && (wmask0 != '0) && w_addr0_ok;
    assign w_rd0 = !w_busy && !csb0 && web0;
    assign w_rd1 = !w_busy && !csb1;

    assign w_old0 = w_addr0_ok ? mem[addr0] : '0;
    assign w_old1 = w_addr1_ok ? mem[addr1] : '0;

    assign w_merged = DATA_WIDTH'(merge_lanes(c_MAX_DATA_WIDTH'(w_old0),
                                              c_MAX_DATA_WIDTH'(din0),
                                              c_MAX_DATA_WIDTH'(wmask0),
                                              c_LANE_W));

    assign w_collide  = w_wr0 && w_rd1 && (addr0 == addr1);
    assign w_rd1_data = (w_collide && BYPASS) ? w_merged : w_old1;

    always_ff @(posedge clk) begin
        if (w_init_we && !rst) begin
            mem[w_init_addr] <= INIT_VALUE;
        end else if (w_wr0) begin
            mem[addr0] <= w_merged;
        end
    end

    logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
    logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
    logic                  dout0_valid_q;
    logic                  dout1_valid_q;
    logic                  collision_q;

    assign dout0_d = w_rd0 ? w_old0 : dout0_q;
    assign dout1_d = w_rd1 ? w_rd1_data : dout1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout0_q       <= '0;
            dout1_q       <= '0;
            dout0_valid_q <= 1'b0;
            dout1_valid_q <= 1'b0;
            collision_q   <= 1'b0;
        end else begin
            dout0_q       <= dout0_d;
            dout1_q       <= dout1_d;
            dout0_valid_q <= w_rd0;
            dout1_valid_q <= w_rd1;
            collision_q   <= w_collide;
        end
    end

    assign dout0       = dout0_q;
    assign dout1       = dout1_q;
    assign dout0_valid = dout0_valid_q;
    assign dout1_valid = dout1_valid_q;
    assign collision   = collision_q;

endmodule

`default_nettype wire
